// File: rtl/alu_divider.sv
// alu_divider: multi-cycle restoring divider for ALU DIV, one quotient bit per cycle with ALU-compatible flags
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] firstOperand,
  input  logic [WIDTH-1:0] secondOperand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state;
  logic sgn, neg_q, neg_r;
  logic [WIDTH-1:0] dvd, dvs, rem, quo, q_fix, r_fix;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] shifted, diff;
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff = shifted - {1'b0, dvs};
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem : rem;
  end
  assign carry = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {sgn, neg_q, neg_r, dvd, dvs, rem, quo, cnt} <= '0;
      {busy, done, result, remainder, divByZero, overflow, zero, negative} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= PREP;
          busy <= 1'b1;
          sgn <= isSigned;
          dvd <= firstOperand;
          dvs <= secondOperand;
        end
        PREP: begin
          rem <= '0;
          cnt <= CW'(WIDTH - 1);
          quo <= (sgn && dvd[WIDTH-1]) ? -dvd : dvd;
          dvs <= (sgn && dvs[WIDTH-1]) ? -dvs : dvs;
          neg_q <= sgn && (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
          neg_r <= sgn && dvd[WIDTH-1];
          state <= ITER;
          // Both special cases bypass the iteration and publish fixed results
          if (dvs == '0) begin
            state <= DONE;
            done <= 1'b1;
            result <= '1;
            remainder <= dvd;
            {divByZero, overflow, zero, negative} <= 4'b1001;
          end else if (sgn && dvd == MIN && dvs == '1) begin
            state <= DONE;
            done <= 1'b1;
            result <= MIN;
            remainder <= '0;
            {divByZero, overflow, zero, negative} <= 4'b0101;
          end
        end
        ITER: begin
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt - 1'b1;
          state <= cnt == '0 ? FIX : ITER;
        end
        FIX: begin
          state <= DONE;
          done <= 1'b1;
          result <= q_fix;
          remainder <= r_fix;
          {divByZero, overflow} <= 2'b00;
          zero <= ~|q_fix;
          negative <= q_fix[WIDTH-1];
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed checks of alu_divider latency, results, flags, reset and start-while-busy
module tb_alu_divider;
  logic clk = 0, rst_n = 0, start = 0, is_signed = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done, div_by_zero, carry, overflow, zero, negative;
  logic [31:0] result, remainder;
  int checks = 0, errors = 0;
  int cyc;
  logic busy_ok;

  alu_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .isSigned(is_signed),
    .firstOperand(a), .secondOperand(b), .busy(busy), .done(done),
    .result(result), .remainder(remainder), .divByZero(div_by_zero),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start is raised in cycle 0; cyc ends as the cycle index in which done is seen.
  task automatic go(input logic [31:0] x, input logic [31:0] y, input logic s, input int inj);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1;
    @(negedge clk);
    start = 0; a = 32'h1234_5678; b = 32'h0000_0003; is_signed = ~s;
    cyc = 1;
    busy_ok = 1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 0;
      @(negedge clk);
      cyc++;
      if (cyc == inj) begin
        start = 1; a = 32'd9; b = 32'd3;
      end else start = 0;
    end
    start = 0;
    if (!busy) busy_ok = 0;
  endtask

  task automatic res(input string tag, input int lat, input logic [31:0] q, input logic [31:0] r, input logic [4:0] fl);
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_q"}, result, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_flags"}, {27'd0, div_by_zero, carry, overflow, zero, negative}, {27'd0, fl});
    @(negedge clk);
    chk({tag, "_after"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_hold_q"}, result, q);
  endtask

  initial begin
    #12;
    chk("rst_outs", {busy, done, div_by_zero, carry, overflow, zero, negative}, 32'd0);
    chk("rst_q", result, 32'd0);
    chk("rst_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1;

    go(32'd100, 32'd7, 0, 0);
    chk("t1_busy", busy_ok, 1);
    res("t1", 35, 32'd14, 32'd2, 5'b00000);

    go(32'hFFFF_FFF9, 32'd2, 1, 0);
    res("t2a", 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'b00001);
    go(32'd7, 32'hFFFF_FFFE, 1, 0);
    res("t2b", 35, 32'hFFFF_FFFD, 32'd1, 5'b00001);

    go(32'd5, 32'd0, 0, 0);
    res("t3u", 2, 32'hFFFF_FFFF, 32'd5, 5'b10001);
    go(32'd5, 32'd0, 1, 0);
    res("t3s", 2, 32'hFFFF_FFFF, 32'd5, 5'b10001);

    go(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    res("t4s", 2, 32'h8000_0000, 32'd0, 5'b00101);
    go(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    res("t4u", 35, 32'd0, 32'h8000_0000, 5'b00010);

    @(negedge clk);
    a = 32'd100; b = 32'd7; is_signed = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("t5_rst_outs", {busy, done, div_by_zero, carry, overflow, zero, negative}, 32'd0);
    chk("t5_rst_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1;
    go(32'd9, 32'd3, 0, 0);
    res("t5", 35, 32'd3, 32'd0, 5'b00000);

    go(32'd1000, 32'd10, 0, 10);
    res("t6", 35, 32'd100, 32'd0, 5'b00000);
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cyc++;
    end
    chk("t6_no_extra_done", cyc, 0);
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
